rc522_spi_sequencer: RTL and testbench

//   Transaction sequencer that sits directly upstream of the SPI master (topSPI) and drives its init/address/dataWr inputs.

---
 rtl/rc522_spi_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_rc522_spi_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc522_spi_sequencer.sv
// rc522_spi_sequencer
// Sits in front of the SPI master and drives its init/address/dataWr
// inputs. After reset it replays a fixed MFRC522 init table, with a settle
// delay after the CommandReg soft reset. After that it serves single-register
// host reads and writes. Read data comes back with a one-cycle ack.
// MFRC522 address byte layout: {rd, reg[5:0], 1'b0}, where rd=1 means read.
module rc522_spi_sequencer #(
    parameter int RST_WAIT = 50000,  // idle cycles after the soft-reset write
    parameter int TIMEOUT  = 4096,   // max cycles in WAIT or RELEASE
    parameter int CNT_W    = 17      // must hold max(RST_WAIT, TIMEOUT)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic       we,
    input  logic [5:0] reg_addr,
    input  logic [7:0] wr_data,
    output logic       ready,
    output logic       ack,
    output logic [7:0] rd_data,
    output logic       error,
    output logic       spi_init,
    output logic [7:0] spi_address,
    output logic [7:0] spi_dataWr,
    input  logic [7:0] spi_dataRd,
    input  logic       spi_done
);

    localparam logic [2:0] ST_BOOT    = 3'd0;
    localparam logic [2:0] ST_ISSUE   = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_RELEASE = 3'd3;
    localparam logic [2:0] ST_DELAY   = 3'd4;
    localparam logic [2:0] ST_IDLE    = 3'd5;
    localparam logic [2:0] ST_FAULT   = 3'd6;

    localparam logic [2:0] IDX_LAST = 3'd7;

    // The counter value in the final allowed cycle. Reaching it and still
    // not being done means the bound has run out.
    localparam logic [CNT_W-1:0] CNT_TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_RW_LAST = CNT_W'(RST_WAIT - 1);

    // Boot table: {reg[5:0], data[7:0]}. Entry 0 is the CommandReg soft reset.
    function automatic logic [13:0] boot_entry(input logic [2:0] i);
        logic [13:0] e;
        case (i)
            3'd0:    e = {6'h01, 8'h0F};  // CommandReg   <- SoftReset
            3'd1:    e = {6'h2A, 8'h8D};  // TModeReg
            3'd2:    e = {6'h2B, 8'h3E};  // TPrescalerReg
            3'd3:    e = {6'h2D, 8'h1E};  // TReloadReg low
            3'd4:    e = {6'h2C, 8'h00};  // TReloadReg high
            3'd5:    e = {6'h15, 8'h40};  // TxASKReg     <- 100% ASK
            3'd6:    e = {6'h11, 8'h3D};  // ModeReg      <- CRC preset 6363
            default: e = {6'h14, 8'h83};  // TxControlReg <- antenna on
        endcase
        return e;
    endfunction

    logic [2:0]       state, state_nxt;
    logic [2:0]       idx, idx_nxt;
    logic [CNT_W-1:0] cnt;
    logic             cnt_run;
    logic             is_host;     // the transaction in flight came from the host
    logic             host_we;     // direction of that host transaction
    logic             load_boot;
    logic             load_host;
    logic             ack_nxt;
    logic             capture_rd;
    logic [5:0]       boot_reg;
    logic [7:0]       boot_data;

    // Status outputs are pure decodes of the state. The reset state is
    // BOOT, so all of them read 0 in the cycle after reset.
    assign ready    = (state == ST_IDLE);
    assign spi_init = (state == ST_ISSUE);
    assign error    = (state == ST_FAULT);

    // Next-state and load-strobe decode.
    always_comb begin
        // NOTE: every signal written in this block is given a default first.
        // A path that skips one of them would otherwise infer a latch.
        state_nxt  = state;
        idx_nxt    = idx;
        load_boot  = 1'b0;
        load_host  = 1'b0;
        ack_nxt    = 1'b0;
        capture_rd = 1'b0;
        cnt_run    = 1'b0;

        case (state)
            ST_BOOT: begin
                load_boot = 1'b1;
                state_nxt = ST_ISSUE;
            end

            ST_ISSUE: begin
                state_nxt = ST_WAIT;
            end

            ST_WAIT: begin
                cnt_run = 1'b1;
                if (spi_done) begin
                    capture_rd = is_host & ~host_we;
                    state_nxt  = ST_RELEASE;
                end else if (cnt == CNT_TO_LAST) begin
                    state_nxt = ST_FAULT;
                end
            end

            ST_RELEASE: begin
                // The SPI master may hold done high. The next transfer
                // must not start until done has dropped.
                cnt_run = 1'b1;
                if (!spi_done) begin
                    if (is_host) begin
                        ack_nxt   = 1'b1;
                        state_nxt = ST_IDLE;
                    end else if (idx == 3'd0) begin
                        state_nxt = ST_DELAY;
                    end else if (idx == IDX_LAST) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        idx_nxt   = idx + 3'd1;
                        load_boot = 1'b1;
                        state_nxt = ST_ISSUE;
                    end
                end else if (cnt == CNT_TO_LAST) begin
                    state_nxt = ST_FAULT;
                end
            end

            ST_DELAY: begin
                // Let the chip settle after the soft reset before the
                // rest of the init table is written.
                cnt_run = 1'b1;
                if (cnt == CNT_RW_LAST) begin
                    idx_nxt   = 3'd1;
                    load_boot = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end

            ST_IDLE: begin
                if (req) begin
                    load_host = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end

            ST_FAULT: begin
                state_nxt = ST_FAULT;
            end

            default: begin
                state_nxt = ST_FAULT;
            end
        endcase

        {boot_reg, boot_data} = boot_entry(idx_nxt);
    end

    // State, counter and datapath registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only. All
        // registers then update together at the edge, with no ordering
        // races between them.
        if (reset) begin
            state       <= ST_BOOT;
            idx         <= 3'd0;
            cnt         <= '0;
            is_host     <= 1'b0;
            host_we     <= 1'b0;
            ack         <= 1'b0;
            rd_data     <= 8'h00;
            spi_address <= 8'h00;
            spi_dataWr  <= 8'h00;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            ack   <= ack_nxt;

            // The counter restarts on every state change. It only counts in
            // the states that are bounded in time.
            if (state_nxt != state) begin
                cnt <= '0;
            end else if (cnt_run) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (capture_rd) begin
                rd_data <= spi_dataRd;
            end

            // Address and data are loaded on entry to ISSUE. They hold until
            // the next load, so the SPI master sees stable values.
            if (load_boot) begin
                spi_address <= {1'b0, boot_reg, 1'b0};
                spi_dataWr  <= boot_data;
                is_host     <= 1'b0;
            end else if (load_host) begin
                spi_address <= {~we, reg_addr, 1'b0};
                spi_dataWr  <= we ? wr_data : 8'h00;
                is_host     <= 1'b1;
                host_we     <= we;
            end
        end
    end

endmodule

// File: tb/tb_rc522_spi_sequencer.sv
// tb_rc522_spi_sequencer
// Randomized self-checking bench. An SPI master model answers each init:
// done rises 10 cycles after init and stays high for a configurable length.
// A behavioural reference model supplies the expected boot sequence, the
// address bytes and the returned read data.
module tb_rc522_spi_sequencer;

    localparam int RST_WAIT = 20;
    localparam int TIMEOUT  = 64;
    localparam int CNT_W    = 17;
    localparam int SPI_LAT  = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req = 1'b0;
    logic       we = 1'b0;
    logic [5:0] reg_addr = 6'h00;
    logic [7:0] wr_data = 8'h00;
    logic       ready;
    logic       ack;
    logic [7:0] rd_data;
    logic       error;
    logic       spi_init;
    logic [7:0] spi_address;
    logic [7:0] spi_dataWr;
    logic [7:0] spi_dataRd;
    logic       spi_done;

    int checks   = 0;
    int failures = 0;

    rc522_spi_sequencer #(
        .RST_WAIT(RST_WAIT),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .we         (we),
        .reg_addr   (reg_addr),
        .wr_data    (wr_data),
        .ready      (ready),
        .ack        (ack),
        .rd_data    (rd_data),
        .error      (error),
        .spi_init   (spi_init),
        .spi_address(spi_address),
        .spi_dataWr (spi_dataWr),
        .spi_dataRd (spi_dataRd),
        .spi_done   (spi_done)
    );

    always #5 clk = ~clk;

    // Reference model: boot table and expected read data
    logic [5:0] boot_reg [8] = '{6'h01, 6'h2A, 6'h2B, 6'h2D, 6'h2C, 6'h15, 6'h11, 6'h14};
    logic [7:0] boot_dat [8] = '{8'h0F, 8'h8D, 8'h3E, 8'h1E, 8'h00, 8'h40, 8'h3D, 8'h83};
    logic [7:0] exp_rd = 8'h00;

    function automatic logic [7:0] exp_addr(input logic w, input logic [5:0] r);
        return 8'((w ? 0 : 128) + 2 * int'(r));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    // SPI master model and activity monitor. Runs at the falling edge.
    bit         resp_en = 1'b1;
    int         done_len = 2;
    logic [7:0] model_rd = 8'h00;
    int         cyc = 0;
    int         ack_cnt = 0;
    logic [7:0] init_addr_q[$];
    logic [7:0] init_data_q[$];
    int         init_cyc_q[$];
    int         fall_cyc_q[$];

    initial begin : spi_model
        int         k;
        bit         busy;
        logic [7:0] lat_addr;
        logic [7:0] lat_data;
        k = 0;
        busy = 1'b0;
        lat_addr = 8'h00;
        lat_data = 8'h00;
        spi_done = 1'b0;
        spi_dataRd = 8'h00;
        forever begin
            @(negedge clk);
            cyc++;
            if (spi_init) begin
                init_addr_q.push_back(spi_address);
                init_data_q.push_back(spi_dataWr);
                init_cyc_q.push_back(cyc);
            end
            if (ack) ack_cnt++;
            if (reset) begin
                busy = 1'b0;
                spi_done = 1'b0;
            end else if (busy) begin
                k++;
                if (k == SPI_LAT && resp_en) begin
                    check("addr_stable", spi_address, lat_addr);
                    check("data_stable", spi_dataWr, lat_data);
                    spi_done = 1'b1;
                    spi_dataRd = model_rd;
                end else if (k == SPI_LAT + done_len) begin
                    if (spi_done) fall_cyc_q.push_back(cyc);
                    spi_done = 1'b0;
                    spi_dataRd = ~model_rd;
                    busy = 1'b0;
                end
            end else if (spi_init) begin
                busy = 1'b1;
                k = 0;
                lat_addr = spi_address;
                lat_data = spi_dataWr;
            end
        end
    end

    task automatic check_zero_outputs;
        check("rst_ready", ready, 0);
        check("rst_ack", ack, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_error", error, 0);
        check("rst_spi_init", spi_init, 0);
        check("rst_spi_address", spi_address, 0);
        check("rst_spi_dataWr", spi_dataWr, 0);
    endtask

    // Reset, then check the full boot replay.
    task automatic run_boot;
        init_addr_q.delete();
        init_data_q.delete();
        init_cyc_q.delete();
        fall_cyc_q.delete();
        ack_cnt = 0;
        req = 1'b0;
        resp_en = 1'b1;
        done_len = 2;
        reset = 1'b1;
        step;
        step;
        exp_rd = 8'h00;
        check_zero_outputs();
        reset = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            step;
            if (ready) break;
        end
        check("boot_ready", ready, 1);
        check("boot_init_count", init_addr_q.size(), 8);
        for (int i = 0; i < 8 && i < init_addr_q.size(); i++) begin
            check($sformatf("boot_addr%0d", i), init_addr_q[i], exp_addr(1'b1, boot_reg[i]));
            check($sformatf("boot_data%0d", i), init_data_q[i], boot_dat[i]);
        end
        if (init_cyc_q.size() >= 2 && fall_cyc_q.size() >= 1)
            check("boot_gap", (init_cyc_q[1] - fall_cyc_q[0]) >= RST_WAIT, 1);
        else
            check("boot_gap_data", 0, 1);
        check("boot_no_ack", ack_cnt, 0);
        check("boot_error", error, 0);
    endtask

    task automatic wait_ready;
        for (int i = 0; i < 200; i++) begin
            if (ready) break;
            step;
        end
        check("wait_ready", ready, 1);
    endtask

    task automatic wait_ack(input int n_init);
        for (int i = 0; i < 200; i++) begin
            step;
            if (ack) break;
        end
        check("ack_seen", ack, 1);
        check("ack_with_ready", ready, 1);
        check("ack_rd_data", rd_data, exp_rd);
        check("single_issue", init_addr_q.size(), n_init);
    endtask

    // Issue one host request, check the first ISSUE cycle, return after the request is accepted.
    task automatic start_txn(input logic w, input logic [5:0] r, input logic [7:0] d, input logic [7:0] rv);
        model_rd = rv;
        req = 1'b1;
        we = w;
        reg_addr = r;
        wr_data = d;
        step;
        req = 1'b0;
        we = 1'($urandom);
        reg_addr = 6'($urandom);
        wr_data = 8'($urandom);
        check("init_latency", spi_init, 1);
        check("busy_not_ready", ready, 0);
        check("host_addr", spi_address, exp_addr(w, r));
        check("host_data", spi_dataWr, w ? d : 8'h00);
        if (!w) exp_rd = rv;
    endtask

    task automatic host_txn(input logic w, input logic [5:0] r, input logic [7:0] d,
                            input logic [7:0] rv, input int dl);
        int n0;
        wait_ready();
        done_len = dl;
        n0 = init_addr_q.size();
        start_txn(w, r, d, rv);
        wait_ack(n0 + 1);
        step;
        check("ack_one_cycle", ack, 0);
    endtask

    // A req while busy is dropped. A req in the ack cycle is accepted.
    task automatic busy_and_ack_cycle_test;
        int n0;
        wait_ready();
        done_len = 2;
        n0 = init_addr_q.size();
        start_txn(1'b0, 6'h21, 8'h00, 8'h6C);
        repeat (3) step;
        req = 1'b1;
        we = 1'b1;
        reg_addr = 6'h3F;
        step;
        req = 1'b0;
        wait_ack(n0 + 1);
        req = 1'b1;
        we = 1'b1;
        reg_addr = 6'h05;
        wr_data = 8'hA5;
        step;
        req = 1'b0;
        check("ack_cycle_accept", spi_init, 1);
        check("ack_cycle_addr", spi_address, exp_addr(1'b1, 6'h05));
        check("ack_cycle_data", spi_dataWr, 8'hA5);
        wait_ack(n0 + 2);
        step;
        check("ack_one_cycle", ack, 0);
    endtask

    // If done never arrives, FAULT is entered exactly TIMEOUT cycles after WAIT entry.
    task automatic timeout_test;
        int n0;
        wait_ready();
        resp_en = 1'b0;
        start_txn(1'b0, 6'h10, 8'h00, 8'h11);
        repeat (TIMEOUT) step;
        check("fault_not_early", error, 0);
        check("fault_wait_ready", ready, 0);
        step;
        check("fault_error", error, 1);
        check("fault_ready", ready, 0);
        check("fault_init", spi_init, 0);
        n0 = init_addr_q.size();
        req = 1'b1;
        step;
        req = 1'b0;
        repeat (20) step;
        check("fault_sticky", error, 1);
        check("fault_sticky_ready", ready, 0);
        check("fault_no_issue", init_addr_q.size(), n0);
        resp_en = 1'b1;
    endtask

    // A reset during WAIT abandons the read and restarts the boot.
    task automatic reset_mid_wait_test;
        wait_ready();
        start_txn(1'b0, 6'h2E, 8'h00, 8'h77);
        repeat (3) step;
        check("in_wait_no_done", spi_done, 0);
        reset = 1'b1;
        step;
        check_zero_outputs();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        run_boot();
        host_txn(1'b0, 6'h37, 8'h00, 8'h92, 2);
        check("read_0x37_addr", init_addr_q[init_addr_q.size() - 1], 8'hEE);
        check("read_0x37_data", rd_data, 8'h92);
        host_txn(1'b1, 6'h09, 8'h26, 8'h00, 2);
        check("write_0x09_addr", init_addr_q[init_addr_q.size() - 1], 8'h12);
        check("write_keeps_rd", rd_data, 8'h92);
        busy_and_ack_cycle_test();
        for (int i = 0; i < 16; i++) begin
            host_txn(1'($urandom), 6'($urandom), 8'($urandom), 8'($urandom),
                     int'($urandom_range(1, 4)));
        end
        timeout_test();
        run_boot();
        host_txn(1'b0, 6'h3A, 8'h00, 8'hC3, 2);
        reset_mid_wait_test();
        run_boot();
        host_txn(1'b0, 6'h37, 8'h00, 8'h5D, 3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
